mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between instruction fetch (I) and load/store (D) requesters.
- Drives `sel`, the select of the shared address/data 2:1 mux: 0 = I, 1 = D.
- Sequences each access with a req/ack handshake and bounds memory wait time with a timeout counter.
- Sits between the IF/MEM pipeline stages and the memory interface; stall logic uses `i_ack`/`d_ack`.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between instruction fetch (I) and load/store (D).
// Define ARB_ROUND_ROBIN_EN to alternate grants under contention instead of fixed D-over-I.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                err,
    output logic                sel,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    // The counter only needs to reach TIMEOUT-1: the last ACCESS cycle is detected before increment.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_q;
    logic               sel_q;
    logic               mem_req_q;
    logic               i_ack_q;
    logic               d_ack_q;
    logic               err_q;
    logic               busy_q;
    logic [DATA_W-1:0]  i_rdata_q;
    logic [DATA_W-1:0]  d_rdata_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               grant_d;
    logic               any_req;
    logic               timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    always_comb begin
        grant_d = d_req;
        if (d_req && i_req) begin
            grant_d = ~last_grant_q;
        end
    end
`else
    always_comb begin
        grant_d = d_req;
    end
`endif

    assign any_req     = i_req | d_req;
    assign cnt_d       = cnt_q + CNT_W'(1);
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            mem_req_q <= 1'b0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            cnt_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        sel_q     <= grant_d;
                        mem_req_q <= 1'b1;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_q <= grant_d;
`endif
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_d;
                    // A completion in the timeout cycle still counts as a good access.
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= DONE;
                        if (sel_q) begin
                            d_rdata_q <= mem_rdata;
                            d_ack_q   <= 1'b1;
                        end else begin
                            i_rdata_q <= mem_rdata;
                            i_ack_q   <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                        if (sel_q) begin
                            d_rdata_q <= '0;
                            d_ack_q   <= 1'b1;
                        end else begin
                            i_rdata_q <= '0;
                            i_ack_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign sel       = sel_q;
    assign mem_req   = mem_req_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

    assign mem_addr  = sel_q ? d_addr : i_addr;
    assign mem_we    = sel_q & d_we;
    assign mem_wdata = d_wdata;
    assign mem_wstrb = sel_q ? d_wstrb : {STRB_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT = 4), with a simple memory responder.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [SW-1:0] d_wstrb;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          err;
    logic          sel;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int i_ack_cnt = 0;
    int d_ack_cnt = 0;

    // Responder: ack_lat = N asserts mem_ack in the N-th cycle of mem_req; 0 never acks.
    int            ack_lat = 2;
    logic          force_ack = 1'b0;
    logic [DW-1:0] rdata_val = '0;
    int            req_age = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_ack(d_ack), .err(err), .sel(sel),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) req_age++;
            else req_age = 0;
            mem_ack   = force_ack || (ack_lat > 0 && mem_req && req_age == ack_lat);
            mem_rdata = rdata_val;
        end
    end

    always @(negedge clk) begin
        if (i_ack) i_ack_cnt++;
        if (d_ack) d_ack_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_wstrb = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sel, mem_req, i_ack, d_ack, err, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b", {sel, mem_req, i_ack, d_ack, err, busy}, 6'b0);
        end
        checks++;
        if ({i_rdata, d_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected %h", {i_rdata, d_rdata}, 64'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected %b", {mem_req, busy}, 2'b00);
        end
    endtask

    task automatic test_i_read;
        int n;
        int bi;
        int bd;
        bi = i_ack_cnt; bd = d_ack_cnt;
        ack_lat = 2; rdata_val = 32'h2408_0005;
        i_addr = 32'h0000_0040; i_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, sel, busy, mem_we, mem_wstrb} !== {3'b101, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL iread_grant: got %b expected %b", {mem_req, sel, busy, mem_we, mem_wstrb}, {3'b101, 1'b0, 4'h0});
        end
        checks++;
        if (mem_addr !== 32'h0000_0040) begin
            errors++;
            $display("FAIL iread_addr: got %h expected %h", mem_addr, 32'h0000_0040);
        end
        n = 1;
        while (!(i_ack || d_ack) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL iread_latency: got %0d expected %0d", n, 3);
        end
        checks++;
        if ({i_ack, d_ack, err, i_rdata} !== {3'b100, 32'h2408_0005}) begin
            errors++;
            $display("FAIL iread_ack_data: got %b/%h expected 100/%h", {i_ack, d_ack, err}, i_rdata, 32'h2408_0005);
        end
        i_req = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({i_ack, busy} !== 2'b00 || i_ack_cnt - bi !== 1 || d_ack_cnt - bd !== 0) begin
            errors++;
            $display("FAIL iread_single_pulse: got ack=%b busy=%b i_acks=%0d d_acks=%0d expected 0 0 1 0",
                     i_ack, busy, i_ack_cnt - bi, d_ack_cnt - bd);
        end
    endtask

    task automatic test_d_access;
        int n;
        int bi;
        int bd;
        bi = i_ack_cnt; bd = d_ack_cnt;
        ack_lat = 2; rdata_val = 32'h5555_AAAA;
        d_we = 1'b1; d_addr = 32'h1000_0010; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF; d_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({mem_req, sel, mem_we, mem_wstrb} !== {3'b111, 4'hF}) begin
            errors++;
            $display("FAIL dwrite_ctrl: got %b expected %b", {mem_req, sel, mem_we, mem_wstrb}, {3'b111, 4'hF});
        end
        checks++;
        if ({mem_addr, mem_wdata} !== {32'h1000_0010, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL dwrite_fields: got %h/%h expected 10000010/deadbeef", mem_addr, mem_wdata);
        end
        n = 1;
        while (!(i_ack || d_ack) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 3 || {i_ack, d_ack, err} !== 3'b010) begin
            errors++;
            $display("FAIL dwrite_ack: got n=%0d ack=%b expected n=3 ack=010", n, {i_ack, d_ack, err});
        end
        d_req = 1'b0;
        @(negedge clk);
        // Immediate-ack load; instruction read data must hold across it.
        ack_lat = 1; rdata_val = 32'h1234_5678;
        d_we = 1'b0; d_addr = 32'h1000_0020; d_wstrb = 4'h0; d_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({sel, mem_we, mem_addr} !== {2'b10, 32'h1000_0020}) begin
            errors++;
            $display("FAIL dread_ctrl: got sel=%b we=%b addr=%h expected 1 0 10000020", sel, mem_we, mem_addr);
        end
        n = 1;
        while (!(i_ack || d_ack) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 2 || d_rdata !== 32'h1234_5678 || i_rdata !== 32'h2408_0005) begin
            errors++;
            $display("FAIL dread_data: got n=%0d d_rdata=%h i_rdata=%h expected 2 12345678 24080005", n, d_rdata, i_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (d_ack_cnt - bd !== 2 || i_ack_cnt - bi !== 0) begin
            errors++;
            $display("FAIL d_ack_count: got d=%0d i=%0d expected d=2 i=0", d_ack_cnt - bd, i_ack_cnt - bi);
        end
    endtask

    task automatic test_contention;
        int nacks;
        logic [3:0] seq;
        logic [3:0] exp_seq;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ack_lat = 1; rdata_val = 32'hCAFE_0001;
        i_addr = 32'h0000_0080; d_addr = 32'h2000_0000; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        nacks = 0; seq = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (d_ack) begin
                if (nacks < 4) seq[nacks] = 1'b1;
                nacks++;
                d_req = 1'b0;
            end
            if (i_ack) begin
                if (nacks < 4) seq[nacks] = 1'b0;
                nacks++;
                i_req = 1'b0;
            end
        end
        checks++;
        if (nacks !== 2 || seq[1:0] !== 2'b01) begin
            errors++;
            $display("FAIL contention_order: got acks=%0d seq=%b expected acks=2 seq=01 (D then I)", nacks, seq[1:0]);
        end
        // Both requesters continuously re-request.
        i_req = 1'b1; d_req = 1'b1;
        nacks = 0; seq = '0;
        for (int k = 0; k < 20 && nacks < 4; k++) begin
            @(negedge clk);
            if (d_ack) begin
                seq[nacks] = 1'b1;
                nacks++;
            end
            if (i_ack) begin
                seq[nacks] = 1'b0;
                nacks++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_seq = 4'b0101;
`else
        exp_seq = 4'b1111;
`endif
        checks++;
        if (nacks !== 4 || seq !== exp_seq) begin
            errors++;
            $display("FAIL contention_continuous: got acks=%0d seq=%b expected acks=4 seq=%b", nacks, seq, exp_seq);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        int n;
        int reqcyc;
        ack_lat = 0;
        d_we = 1'b0; d_addr = 32'h3000_0000; d_req = 1'b1;
        n = 0; reqcyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (mem_req) reqcyc++;
            if (i_ack || d_ack) break;
        end
        checks++;
        if (n !== 5 || reqcyc !== 4) begin
            errors++;
            $display("FAIL timeout_timing: got ack_cycle=%0d req_cycles=%0d expected 5 4", n, reqcyc);
        end
        checks++;
        if ({d_ack, i_ack, err} !== 3'b101 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_ack: got ack/err=%b d_rdata=%h expected 101 00000000", {d_ack, i_ack, err}, d_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, err, d_ack, mem_req} !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_recover: got %b expected 0000", {busy, err, d_ack, mem_req});
        end
        // Completion landing in the very cycle the timeout would fire.
        ack_lat = TO; rdata_val = 32'h0F0F_F0F0;
        d_req = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (i_ack || d_ack) break;
        end
        checks++;
        if (n !== 5 || {d_ack, err} !== 2'b10 || d_rdata !== 32'h0F0F_F0F0) begin
            errors++;
            $display("FAIL ack_beats_timeout: got n=%0d ack/err=%b d_rdata=%h expected 5 10 0f0ff0f0", n, {d_ack, err}, d_rdata);
        end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int bi;
        int bd;
        ack_lat = 0;
        d_we = 1'b1; d_addr = 32'h4000_0000; d_wstrb = 4'h3; d_req = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_req, sel, busy} !== 3'b111) begin
            errors++;
            $display("FAIL rstmid_pre: got %b expected 111", {mem_req, sel, busy});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_req, sel, busy, i_ack, d_ack, err} !== 6'b0) begin
            errors++;
            $display("FAIL rstmid_async: got %b expected 000000", {mem_req, sel, busy, i_ack, d_ack, err});
        end
        d_req = 1'b0;
        bi = i_ack_cnt; bd = d_ack_cnt;
        @(negedge clk);
        rst = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        force_ack = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (i_ack_cnt - bi !== 0 || d_ack_cnt - bd !== 0 || {busy, mem_req} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_no_ack: got i=%0d d=%0d busy/req=%b expected 0 0 00",
                     i_ack_cnt - bi, d_ack_cnt - bd, {busy, mem_req});
        end
    endtask

    task automatic test_back_to_back;
        int nacks;
        int t[3];
        ack_lat = 1; rdata_val = 32'h7777_0000;
        i_addr = 32'h0000_0100; i_req = 1'b1;
        nacks = 0; t[0] = 0; t[1] = 0; t[2] = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                if (nacks < 3) t[nacks] = k;
                nacks++;
                if (nacks == 3) i_req = 1'b0;
            end
        end
        checks++;
        if (nacks !== 3 || t[0] !== 2 || t[1] !== 5 || t[2] !== 8) begin
            errors++;
            $display("FAIL back_to_back: got acks=%0d at %0d,%0d,%0d expected 3 at 2,5,8", nacks, t[0], t[1], t[2]);
        end
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_access();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
